square_wave_out: RTL
====================

// Module: square_wave_out
// PURPOSE
//  Output stage of the square-wave generator. Consumes the period (quotient, in clk
//  cycles) and high-time produced by the upstream divider and drives a glitch-free,
//  registered square wave. New settings are double-buffered and take effect only on a
//  period boundary, so the waveform never shows a truncated or stretched cycle.
// PARAMETERS
//  WIDTH       32  width of period/high-time operands (matches divider quotient)
//  MIN_PERIOD  2   smallest period in clk cycles; smaller requests are clamped up to it
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      1 = run waveform, 0 = stop and park output low
//  cfg_period   in   WIDTH  requested period in clk cycles (divider quotient)
//  cfg_high     in   WIDTH  requested high time in clk cycles
//  cfg_valid    in   1      cfg_period/cfg_high are valid
//  cfg_ready    out  1      stage can accept a config (no config pending)
//  wave_out     out  1      square wave, registered
//  period_tick  out  1      1-cycle pulse on the last cycle of every period
//  running      out  1      1 while in RUN
// BEHAVIOUR
//  Reset: wave_out=0, period_tick=0, running=0, cfg_ready=1, cnt=0, state=IDLE,
//    active regs per_q=MIN_PERIOD, hi_q=0, cfg_loaded=0, pending=0.
//  Handshake: transfer when cfg_valid & cfg_ready at a rising edge; cfg_ready = !pending.
//    Inputs are sampled only on transfer; cfg_valid without cfg_ready is held, not lost.
//  Clamping at capture: per = max(cfg_period, MIN_PERIOD); hi = min(cfg_high, per).
//  States: IDLE, RUN.
//  IDLE: cnt=0, wave_out=0. Transfer writes per_q/hi_q directly, sets cfg_loaded.
//    IDLE->RUN at an edge where en=1 and cfg_loaded=1 (cfg_loaded as of before that edge);
//    on that edge cnt=0, running=1, wave_out=(hi_q!=0).
//  RUN: each edge cnt <= (cnt==per_q-1) ? 0 : cnt+1.
//    wave_out is registered from the next cnt: wave_out <= (cnt_next < hi_q), so it
//    is high exactly hi_q cycles per period of per_q cycles, beginning at cnt=0.
//    period_tick = (state==RUN) & (cnt==per_q-1), combinational from registers.
//    Transfer in RUN goes to shadow regs and sets pending (cfg_ready drops next cycle).
//    At the wrap edge (cnt==per_q-1) with pending: per_q/hi_q <= shadow, pending <= 0,
//      and wave_out for cnt=0 uses the NEW hi_q. Transfer on the wrap edge itself is
//      captured into shadow and applies at the following wrap.
//  hi_q=0 -> wave_out constant 0; hi_q=per_q -> constant 1; period_tick still pulses.
//  en=0 in RUN: next edge -> IDLE, cnt=0, wave_out=0, running=0. If pending, shadow is
//    promoted to per_q/hi_q on that same edge and pending cleared; cfg_loaded stays 1.
//    Re-asserting en restarts at cnt=0 (phase not preserved).
//  Counter is WIDTH bits; per_q>=MIN_PERIOD>=2 guarantees cnt never exceeds per_q-1.
//  Reset asserted mid-period: outputs go to reset values immediately (async),
//    any pending config is discarded.
// TESTING
//  1 cfg 10/3, en=1 -> wave_out 3 high,7 low repeating; period_tick every 10th cycle.
//  2 RUN 10/3, load 6/2 at cnt=4 -> current period completes at 10 cycles, then 6/2;
//    cfg_ready low from cycle after transfer until wrap edge.
//  3 cfg 1/5 -> clamped to 2/2: wave_out constant 1, period_tick every 2 cycles;
//    cfg 8/0 -> wave_out constant 0, running=1.
//  4 en=0 at cnt=5 of 10/3 -> next cycle wave_out=0, running=0; en=1 -> fresh period
//    starts at cnt=0, wave_out high 3 cycles.
//  5 pending 4/1 then second cfg_valid held high -> not accepted until wrap; then
//    accepted next cycle and applied at following wrap.
//  6 rst_n low mid-high-phase -> wave_out=0 same cycle; after release, IDLE with
//    cfg_ready=1, no output until a new config and en=1.

Source files
------------

// File: rtl/square_wave_out.sv
// Output stage of the square-wave generator: turns a clamped period/high-time pair into
// a registered square wave, with double-buffered settings that switch only on period wraps.
module square_wave_out #(
   parameter int WIDTH      = 32,
   parameter int MIN_PERIOD = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [WIDTH-1:0] cfg_high,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             wave_out,
   output logic             period_tick,
   output logic             running
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_per_q;
   logic [WIDTH-1:0] r_hi_q;
   logic [WIDTH-1:0] r_sh_per;
   logic [WIDTH-1:0] r_sh_hi;
   logic             r_cfg_loaded;
   logic             r_pending;
   logic             r_wave;
   logic             r_running;

   logic             w_xfer;
   logic             w_wrap;
   logic [WIDTH-1:0] w_cap_per;
   logic [WIDTH-1:0] w_cap_hi;
   logic [WIDTH-1:0] w_cnt_next;
   logic [WIDTH-1:0] w_start_hi;

   assign w_xfer     = cfg_valid & ~r_pending;
   assign w_cap_per  = (cfg_period < MIN_P) ? MIN_P : cfg_period;
   assign w_cap_hi   = (cfg_high > w_cap_per) ? w_cap_per : cfg_high;
   assign w_wrap     = (r_cnt == (r_per_q - WIDTH'(1)));
   assign w_cnt_next = w_wrap ? '0 : (r_cnt + WIDTH'(1));
   // A config landing on the start edge is already the active one for cnt=0.
   assign w_start_hi = w_xfer ? w_cap_hi : r_hi_q;

   assign cfg_ready   = ~r_pending;
   assign wave_out    = r_wave;
   assign running     = r_running;
   assign period_tick = (r_state == RUN) & w_wrap;

   // NOTE: all state lives in this one clocked block using non-blocking assignments,
   // so every right-hand side sees pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_per_q      <= MIN_P;
         r_hi_q       <= '0;
         r_sh_per     <= MIN_P;
         r_sh_hi      <= '0;
         r_cfg_loaded <= 1'b0;
         r_pending    <= 1'b0;
         r_wave       <= 1'b0;
         r_running    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt  <= '0;
               r_wave <= 1'b0;
               if (w_xfer) begin
                  r_per_q      <= w_cap_per;
                  r_hi_q       <= w_cap_hi;
                  r_cfg_loaded <= 1'b1;
               end
               if (en && r_cfg_loaded) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
                  r_wave    <= (w_start_hi != '0);
               end
            end

            RUN: begin
               if (!en) begin
                  r_state   <= IDLE;
                  r_cnt     <= '0;
                  r_wave    <= 1'b0;
                  r_running <= 1'b0;
                  if (r_pending) begin
                     r_per_q   <= r_sh_per;
                     r_hi_q    <= r_sh_hi;
                     r_pending <= 1'b0;
                  end
                  // Only possible with nothing pending, so it never collides with the promotion.
                  if (w_xfer) begin
                     r_per_q <= w_cap_per;
                     r_hi_q  <= w_cap_hi;
                  end
               end else begin
                  r_cnt <= w_cnt_next;
                  if (w_wrap && r_pending) begin
                     r_per_q   <= r_sh_per;
                     r_hi_q    <= r_sh_hi;
                     r_pending <= 1'b0;
                     r_wave    <= (r_sh_hi != '0);
                  end else begin
                     r_wave <= (w_cnt_next < r_hi_q);
                  end
                  if (w_xfer) begin
                     r_sh_per  <= w_cap_per;
                     r_sh_hi   <= w_cap_hi;
                     r_pending <= 1'b1;
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
